mux_arbiter_rr: RTL and testbench

MUX_ARBITER_RR -- requirements
Module: mux_arbiter_rr

---
 rtl/mux_arbiter_rr.sv | 89 ++++++++
 tb/tb_mux_arbiter_rr.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter_rr.sv
// Two-requester round-robin burst arbiter feeding one registered output slot.
// A grant lasts until a last beat or MAX_BEATS beats, then the pointer flips.
module mux_arbiter_rr #(
  parameter int WIDTH     = 2,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t           state;
  logic             ptr;
  logic [CNT_W-1:0] cnt;

  logic             out_free;
  logic             acc0;
  logic             acc1;
  logic             acc;
  logic             acc_last;
  logic [WIDTH-1:0] acc_data;
  logic             rel;

  // Ready depends only on registered state and the downstream handshake.
  assign out_free   = !out_valid || out_ready;
  assign req0_ready = (state == GNT0) && out_free;
  assign req1_ready = (state == GNT1) && out_free;

  assign acc0     = req0_valid && req0_ready;
  assign acc1     = req1_valid && req1_ready;
  assign acc      = acc0 || acc1;
  assign acc_last = acc1 ? req1_last : req0_last;
  assign acc_data = acc1 ? req1_data : req0_data;
  assign rel      = acc && (acc_last || (cnt == CNT_W'(MAX_BEATS - 1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid && req1_valid) state <= ptr ? GNT1 : GNT0;
          else if (req0_valid)          state <= GNT0;
          else if (req1_valid)          state <= GNT1;
        end
        GNT0, GNT1: begin
          if (rel) begin
            state <= IDLE;
            ptr   <= (state == GNT0);
            cnt   <= '0;
          end else if (acc) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Output slot: a new beat overwrites a draining one in the same cycle.
      if (acc) begin
        out_valid <= 1'b1;
        out_data  <= acc_data;
        out_sel   <= acc1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter_rr.sv
// Directed bench for mux_arbiter_rr (WIDTH=2, MAX_BEATS=4).
module tb_mux_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_last, req0_ready;
  logic [1:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [1:0] req1_data;
  logic       out_valid, out_sel, out_ready;
  logic [1:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  mux_arbiter_rr #(.WIDTH(2), .MAX_BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] d, input logic s);
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, "_data"},  {30'd0, out_data},  {30'd0, d});
    chk({tag, "_sel"},   {31'd0, out_sel},   {31'd0, s});
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, "_rdy0"}, {31'd0, req0_ready}, {31'd0, r0});
    chk({tag, "_rdy1"}, {31'd0, req1_ready}, {31'd0, r1});
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0;
    req0_valid = 1'b0; req0_data = 2'b00; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = 2'b00; req1_last = 1'b0;
    tick(); tick();
    chk_out("reset", 1'b0, 2'b00, 1'b0);
    chk_rdy("reset", 1'b0, 1'b0);

    // Basic burst then other requester after an IDLE cycle
    rst_n = 1'b1; out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 2'b01; req0_last = 1'b0;
    req1_valid = 1'b1; req1_data = 2'b11; req1_last = 1'b1;
    #1 chk_rdy("idle_arb", 1'b0, 1'b0);
    tick();
    chk_rdy("gnt0", 1'b1, 1'b0);
    tick();
    chk_out("b31_1", 1'b1, 2'b01, 1'b0);
    req0_data = 2'b10; req0_last = 1'b1;
    tick();
    chk_out("b31_2", 1'b1, 2'b10, 1'b0);
    chk_rdy("b31_idle", 1'b0, 1'b0);
    req0_valid = 1'b0;
    tick();
    chk_out("b31_drain", 1'b0, 2'b10, 1'b0);
    chk_rdy("b31_gnt1", 1'b0, 1'b1);
    tick();
    chk_out("b31_3", 1'b1, 2'b11, 1'b1);
    req1_valid = 1'b0;
    tick();
    chk("b31_empty", {31'd0, out_valid}, 32'd0);

    // Alternation with single-beat bursts
    req0_valid = 1'b1; req0_data = 2'b00; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 2'b01; req1_last = 1'b1;
    tick();
    chk_rdy("alt_g0", 1'b1, 1'b0);
    tick();
    chk_out("alt_o0", 1'b1, 2'b00, 1'b0);
    chk_rdy("alt_i0", 1'b0, 1'b0);
    tick();
    chk_rdy("alt_g1", 1'b0, 1'b1);
    tick();
    chk_out("alt_o1", 1'b1, 2'b01, 1'b1);
    chk_rdy("alt_i1", 1'b0, 1'b0);
    tick();
    chk_rdy("alt_g2", 1'b1, 1'b0);
    tick();
    chk_out("alt_o2", 1'b1, 2'b00, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("alt_empty", {31'd0, out_valid}, 32'd0);

    // Forced release after MAX_BEATS; pointer is 1 here
    req0_valid = 1'b1; req0_data = 2'd0; req0_last = 1'b0;
    tick();
    chk_rdy("max_g0", 1'b1, 1'b0);
    req1_valid = 1'b1; req1_data = 2'b10; req1_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_data = 2'(i);
      tick();
      chk_out("max_beat", 1'b1, 2'(i), 1'b0);
      if (i < 3) chk_rdy("max_hold", 1'b1, 1'b0);
    end
    chk_rdy("max_rel", 1'b0, 1'b0);
    req0_data = 2'd0;
    tick();
    chk_rdy("max_g1", 1'b0, 1'b1);
    tick();
    chk_out("max_r1", 1'b1, 2'b10, 1'b1);
    req1_valid = 1'b0;
    tick();
    chk_rdy("max_resume", 1'b1, 1'b0);
    tick();
    chk_out("max_b4", 1'b1, 2'd0, 1'b0);
    req0_data = 2'd1; req0_last = 1'b1;
    tick();
    chk_out("max_b5", 1'b1, 2'd1, 1'b0);
    req0_valid = 1'b0;
    tick();

    // Backpressure: held beat stays, ready low; drain and accept together
    req1_valid = 1'b1; req1_data = 2'b01; req1_last = 1'b0;
    tick();
    chk_rdy("bp_g1", 1'b0, 1'b1);
    tick();
    out_ready = 1'b0; req1_data = 2'b10;
    #1 chk_rdy("bp_stall0", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("bp_hold", 1'b1, 2'b01, 1'b1);
      chk_rdy("bp_stall", 1'b0, 1'b0);
    end
    out_ready = 1'b1; req1_last = 1'b1;
    #1 chk_rdy("bp_resume", 1'b0, 1'b1);
    tick();
    chk_out("bp_next", 1'b1, 2'b10, 1'b1);
    req1_valid = 1'b0;
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Grant held while requester 0 pauses mid-burst
    req0_valid = 1'b1; req0_data = 2'b00; req0_last = 1'b0;
    req1_valid = 1'b1; req1_data = 2'b11; req1_last = 1'b1;
    tick();
    chk_rdy("gap_g0", 1'b1, 1'b0);
    tick();
    chk_out("gap_b0", 1'b1, 2'b00, 1'b0);
    req0_valid = 1'b0;
    tick();
    chk_out("gap_drain", 1'b0, 2'b00, 1'b0);
    chk_rdy("gap_w1", 1'b1, 1'b0);
    tick();
    chk_rdy("gap_w2", 1'b1, 1'b0);
    req0_valid = 1'b1; req0_data = 2'b01; req0_last = 1'b1;
    tick();
    chk_out("gap_b1", 1'b1, 2'b01, 1'b0);
    req0_valid = 1'b0; req1_last = 1'b0;
    tick();
    chk_rdy("gap_g1", 1'b0, 1'b1);

    // Reset during GNT1 with a held beat; pointer back to 0
    tick();
    chk_out("rst_pre", 1'b1, 2'b11, 1'b1);
    rst_n = 1'b0;
    tick();
    chk_out("rst_mid", 1'b0, 2'b00, 1'b0);
    chk_rdy("rst_mid", 1'b0, 1'b0);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 2'b10; req0_last = 1'b0;
    tick();
    chk_rdy("rst_ptr", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk_rdy("rst_cnt", 1'b0, 1'b0);
    chk_out("rst_last", 1'b1, 2'b10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
